// File: rtl/tx_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tx_fifo_arbiter
// Purpose  : Packet-locked round-robin arbiter that shares the single UART TX
//            FIFO write port between two byte-stream requesters.
//            Requester 0 = ALU result path, requester 1 = status/diagnostics.
//            The owner keeps the port until it writes a LAST byte, or until
//            its REQ has been low for TXARB_TIMEOUT consecutive cycles.
// Ports    : i_clk / i_reset          clock, synchronous active-low reset
//            i_txarb_REQx/DATAx/LASTx requester byte streams (x = 0,1)
//            i_txarb_FULL             TX FIFO full (used combinationally)
//            i_txarb_ERRCLR           clears the sticky timeout flag
//            o_txarb_ACKx             byte of requester x accepted this cycle
//            o_txarb_WRITE/WRITEDATA  TX FIFO write strobe and data
//            o_txarb_BUSY             a grant is held
//            o_txarb_OWNER            current or last owner index
//            o_txarb_ERR              sticky: a grant was released by timeout
// Revision : 1.0 - initial release
// ============================================================================
module tx_fifo_arbiter #(
    parameter int NB_TXARB_DATA    = 8,
    parameter int NB_TXARB_TIMEOUT = 4,
    parameter int TXARB_TIMEOUT    = 10
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_txarb_REQ0,
    input  logic [NB_TXARB_DATA-1:0] i_txarb_DATA0,
    input  logic                     i_txarb_LAST0,
    input  logic                     i_txarb_REQ1,
    input  logic [NB_TXARB_DATA-1:0] i_txarb_DATA1,
    input  logic                     i_txarb_LAST1,
    input  logic                     i_txarb_FULL,
    input  logic                     i_txarb_ERRCLR,
    output logic                     o_txarb_ACK0,
    output logic                     o_txarb_ACK1,
    output logic                     o_txarb_WRITE,
    output logic [NB_TXARB_DATA-1:0] o_txarb_WRITEDATA,
    output logic                     o_txarb_BUSY,
    output logic                     o_txarb_OWNER,
    output logic                     o_txarb_ERR
);

    localparam logic [0:0] c_S_IDLE   = 1'b0;
    localparam logic [0:0] c_S_LOCKED = 1'b1;

    // Counter value seen on the last idle cycle before a forced release.
    localparam logic [NB_TXARB_TIMEOUT-1:0] c_CNT_LAST = NB_TXARB_TIMEOUT'(TXARB_TIMEOUT - 1);
    localparam logic [NB_TXARB_TIMEOUT-1:0] c_CNT_ONE  = NB_TXARB_TIMEOUT'(1);

    logic [0:0]                  r_state;
    logic                        r_owner;
    logic                        r_last_served;
    logic [NB_TXARB_TIMEOUT-1:0] r_cnt;
    logic                        r_err;

    logic [0:0]                  w_state_nxt;
    logic                        w_owner_nxt;
    logic                        w_last_served_nxt;
    logic [NB_TXARB_TIMEOUT-1:0] w_cnt_nxt;
    logic                        w_err_set;

    logic                        w_req_own;
    logic                        w_last_own;
    logic [NB_TXARB_DATA-1:0]    w_data_own;
    logic                        w_accept;

    // Owner-side view of the requester inputs.
    assign w_req_own  = r_owner ? i_txarb_REQ1  : i_txarb_REQ0;
    assign w_last_own = r_owner ? i_txarb_LAST1 : i_txarb_LAST0;
    assign w_data_own = r_owner ? i_txarb_DATA1 : i_txarb_DATA0;

    // FULL gates the accept directly, so a write never lands on a full FIFO.
    assign w_accept = (r_state == c_S_LOCKED) & w_req_own & ~i_txarb_FULL;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state       <= c_S_IDLE;
            r_owner       <= 1'b0;
            r_last_served <= 1'b1;   // requester 0 wins the first tie
            r_cnt         <= '0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_owner       <= w_owner_nxt;
            r_last_served <= w_last_served_nxt;
            r_cnt         <= w_cnt_nxt;
            // A timeout in the same cycle as a clear keeps the flag set.
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (i_txarb_ERRCLR) begin
                r_err <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_owner_nxt       = r_owner;
        w_last_served_nxt = r_last_served;
        w_cnt_nxt         = r_cnt;
        w_err_set         = 1'b0;

        case (r_state)
            c_S_IDLE: begin
                w_cnt_nxt = '0;
                if (i_txarb_REQ0 | i_txarb_REQ1) begin
                    w_state_nxt = c_S_LOCKED;
                    if (i_txarb_REQ0 & i_txarb_REQ1) begin
                        w_owner_nxt = ~r_last_served;
                    end else begin
                        w_owner_nxt = i_txarb_REQ1;
                    end
                end
            end

            c_S_LOCKED: begin
                if (w_req_own) begin
                    // REQ high with FULL high is a pure stall: counter holds.
                    if (!i_txarb_FULL) begin
                        w_cnt_nxt = '0;
                        if (w_last_own) begin
                            w_state_nxt       = c_S_IDLE;
                            w_last_served_nxt = r_owner;
                        end
                    end
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt       = c_S_IDLE;
                    w_last_served_nxt = r_owner;
                    w_cnt_nxt         = '0;
                    w_err_set         = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end

            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    assign o_txarb_WRITE     = w_accept;
    assign o_txarb_WRITEDATA = w_accept ? w_data_own : '0;
    assign o_txarb_ACK0      = w_accept & ~r_owner;
    assign o_txarb_ACK1      = w_accept &  r_owner;
    assign o_txarb_BUSY      = (r_state == c_S_LOCKED);
    assign o_txarb_OWNER     = r_owner;
    assign o_txarb_ERR       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tx_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_fifo_arbiter
// Purpose  : Scoreboard bench for tx_fifo_arbiter. Two behavioural requesters
//            replay byte queues; expected FIFO writes ({owner, byte}) are
//            pushed when a packet is issued and popped by a monitor whenever
//            the DUT strobes WRITE.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_fifo_arbiter;

    localparam int NB_D = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0, req1, last0, last1, full, errclr;
    logic [NB_D-1:0] data0, data1;

    logic            w_ack0, w_ack1, w_write, w_busy, w_owner, w_err;
    logic [NB_D-1:0] w_wdata;

    // Requester byte queues: {last, data}; expected writes: {owner, data}.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] exp_q[$];

    bit ack0_seen = 1'b0;
    bit ack1_seen = 1'b0;
    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tx_fifo_arbiter #(
        .NB_TXARB_DATA   (NB_D),
        .NB_TXARB_TIMEOUT(4),
        .TXARB_TIMEOUT   (10)
    ) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_txarb_REQ0     (req0),
        .i_txarb_DATA0    (data0),
        .i_txarb_LAST0    (last0),
        .i_txarb_REQ1     (req1),
        .i_txarb_DATA1    (data1),
        .i_txarb_LAST1    (last1),
        .i_txarb_FULL     (full),
        .i_txarb_ERRCLR   (errclr),
        .o_txarb_ACK0     (w_ack0),
        .o_txarb_ACK1     (w_ack1),
        .o_txarb_WRITE    (w_write),
        .o_txarb_WRITEDATA(w_wdata),
        .o_txarb_BUSY     (w_busy),
        .o_txarb_OWNER    (w_owner),
        .o_txarb_ERR      (w_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Requesters: advance past a byte whose ACK was seen in the previous cycle.
    always @(posedge clk) begin
        #1;
        if (ack0_seen && q0.size() > 0) void'(q0.pop_front());
        if (ack1_seen && q1.size() > 0) void'(q1.pop_front());
        req0  = (q0.size() > 0);
        data0 = req0 ? q0[0][7:0] : '0;
        last0 = req0 ? q0[0][8]   : 1'b0;
        req1  = (q1.size() > 0);
        data1 = req1 ? q1[0][7:0] : '0;
        last1 = req1 ? q1[0][8]   : 1'b0;
    end

    // Monitor: protocol invariants every cycle, scoreboard pop on each write.
    always @(negedge clk) begin
        logic       ok;
        logic [8:0] e;
        ack0_seen = w_ack0;
        ack1_seen = w_ack1;
        ok = !(w_write && full) && !((w_ack0 || w_ack1) && !w_busy) && !(w_ack0 && w_ack1)
             && (w_write == (w_ack0 || w_ack1)) && !(w_ack1 && !w_owner) && !(w_ack0 && w_owner);
        check("protocol", {31'd0, ok}, 32'd1);
        if (w_write) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got owner %0d byte 0x%0h, expected no write (t=%0t)",
                         w_ack1, w_wdata, $time);
            end else begin
                e = exp_q.pop_front();
                check("write_owner_data", {23'd0, w_ack1, w_wdata}, {23'd0, e});
            end
        end
    end

    task automatic after_negedge();
        @(negedge clk);
        #1;
    endtask

    // Wait (bounded) until the scoreboard holds 'target' entries.
    task automatic wait_size(input int target, input int bound, output int cycles);
        cycles = 0;
        while (exp_q.size() != target && cycles < bound) begin
            after_negedge();
            cycles++;
        end
        if (exp_q.size() != target) begin
            check("scoreboard_wait", exp_q.size(), target);
            while (exp_q.size() > target) void'(exp_q.pop_front());
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        after_negedge();
        rst = 1'b1;
    endtask

    initial begin
        int cyc;
        rst = 1'b0; full = 1'b0; errclr = 1'b0;
        req0 = 1'b0; req1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
        data0 = '0; data1 = '0;

        // Reset state.
        repeat (3) after_negedge();
        check("reset_outputs", {w_busy, w_owner, w_err, w_write, w_ack0, w_ack1, w_wdata}, 32'd0);
        rst = 1'b1;
        after_negedge();

        // Single packet on requester 0.
        q0.push_back(9'h00A); q0.push_back(9'h00B); q0.push_back(9'h1AC);
        exp_q.push_back(9'h00A); exp_q.push_back(9'h00B); exp_q.push_back(9'h0AC);
        after_negedge();
        check("grant_latency_busy0", w_busy, 1'b0);
        after_negedge();
        check("grant_latency_busy1", w_busy, 1'b1);
        wait_size(0, 10, cyc);
        check("stream_cycles", cyc, 2);
        after_negedge();
        check("single_busy_after_last", w_busy, 1'b0);
        check("single_err", w_err, 1'b0);

        // Tie and round-robin from a fresh reset: order 0,1,0,1.
        do_reset();
        q0.push_back(9'h010); q0.push_back(9'h111); q0.push_back(9'h012); q0.push_back(9'h113);
        q1.push_back(9'h020); q1.push_back(9'h121); q1.push_back(9'h022); q1.push_back(9'h123);
        exp_q.push_back(9'h010); exp_q.push_back(9'h011);
        exp_q.push_back(9'h120); exp_q.push_back(9'h121);
        exp_q.push_back(9'h012); exp_q.push_back(9'h013);
        exp_q.push_back(9'h122); exp_q.push_back(9'h123);
        wait_size(0, 40, cyc);
        after_negedge();
        check("rr_busy_after", w_busy, 1'b0);

        // Backpressure: FULL for 5 cycles after the first byte.
        q0.push_back(9'h030); q0.push_back(9'h031); q0.push_back(9'h132);
        exp_q.push_back(9'h030); exp_q.push_back(9'h031); exp_q.push_back(9'h032);
        wait_size(2, 10, cyc);
        @(posedge clk); #1;
        full = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("stall_no_progress", exp_q.size(), 2);
        check("stall_busy", w_busy, 1'b1);
        full = 1'b0;
        wait_size(0, 10, cyc);
        after_negedge();
        check("bp_err", w_err, 1'b0);
        check("bp_busy_after", w_busy, 1'b0);

        // Timeout: owner 1 writes 0x55 without LAST then goes quiet.
        q1.push_back(9'h055);
        exp_q.push_back(9'h155); exp_q.push_back(9'h066);
        wait_size(1, 10, cyc);
        q0.push_back(9'h166);
        repeat (10) after_negedge();
        check("to_busy_before", w_busy, 1'b1);
        check("to_owner_before", w_owner, 1'b1);
        check("to_err_before", w_err, 1'b0);
        after_negedge();
        check("to_busy_released", w_busy, 1'b0);
        check("to_err_set", w_err, 1'b1);
        after_negedge();
        check("to_pending_grant_busy", w_busy, 1'b1);
        check("to_pending_grant_owner", w_owner, 1'b0);
        wait_size(0, 5, cyc);
        after_negedge();
        check("err_sticky", w_err, 1'b1);
        errclr = 1'b1;
        after_negedge();
        errclr = 1'b0;
        check("err_cleared", w_err, 1'b0);

        // Reset mid-packet on requester 1.
        q1.push_back(9'h070); q1.push_back(9'h071); q1.push_back(9'h072);
        q1.push_back(9'h073); q1.push_back(9'h074); q1.push_back(9'h175);
        exp_q.push_back(9'h170); exp_q.push_back(9'h171);
        wait_size(0, 10, cyc);
        check("mid_owner_before_reset", w_owner, 1'b1);
        rst = 1'b0;
        q0.delete();
        q1.delete();
        after_negedge();
        check("mid_reset_outputs", {w_busy, w_owner, w_err, w_write, w_ack0, w_ack1, w_wdata}, 32'd0);
        rst = 1'b1;
        q0.push_back(9'h080); q0.push_back(9'h181);
        q1.push_back(9'h190);
        exp_q.push_back(9'h080); exp_q.push_back(9'h081); exp_q.push_back(9'h190);
        wait_size(0, 20, cyc);
        repeat (3) after_negedge();
        check("scoreboard_drained", exp_q.size(), 0);
        check("final_busy", w_busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tx_fifo_arbiter.md
# tx_fifo_arbiter

Round-robin arbiter sharing the single UART TX FIFO write port between two byte-stream requesters. Requester 0 is the ALU interface result path; requester 1 is the status/diagnostic message path. Grants are packet-locked: once a requester owns the port, it keeps it until it writes a byte flagged LAST or until an idle timeout expires. Write data and strobes are a combinational mux of the owner's inputs, so the TX FIFO never overflows and throughput is one byte per cycle.

## Interface
- NB_TXARB_DATA, 8, byte width of requester data and FIFO write data
- NB_TXARB_TIMEOUT, 4, width of the idle-timeout counter
- TXARB_TIMEOUT, 10, consecutive cycles with owner REQ low before forced release (1..2^NB_TXARB_TIMEOUT-1)

- i_clk  in  1  system clock, all logic on rising edge
- i_reset  in  1  synchronous, active-low reset (0 = reset)
- i_txarb_REQ0  in  1  requester 0 has a valid byte on DATA0
- i_txarb_DATA0  in  NB_TXARB_DATA  requester 0 byte
- i_txarb_LAST0  in  1  DATA0 is the final byte of its packet
- i_txarb_REQ1  in  1  requester 1 has a valid byte on DATA1
- i_txarb_DATA1  in  NB_TXARB_DATA  requester 1 byte
- i_txarb_LAST1  in  1  DATA1 is the final byte of its packet
- i_txarb_FULL  in  1  TX FIFO full
- i_txarb_ERRCLR  in  1  clears the sticky ERR flag
- o_txarb_ACK0  out  1  requester 0 byte accepted this cycle; requester advances on this edge
- o_txarb_ACK1  out  1  requester 1 byte accepted this cycle
- o_txarb_WRITE  out  1  TX FIFO write strobe
- o_txarb_WRITEDATA  out  NB_TXARB_DATA  TX FIFO write data
- o_txarb_BUSY  out  1  a grant is held (state LOCKED)
- o_txarb_OWNER  out  1  current or last owner index
- o_txarb_ERR  out  1  sticky: a grant was released by timeout

## Operation
- Registered state: state {IDLE, LOCKED}, owner, last_served, idle counter, ERR.
- IDLE: no writes, no ACKs.
  - Only one REQ is high: that requester becomes owner.
  - Both REQs are high: the requester not equal to last_served becomes owner.
  - Next state is LOCKED. Counter clears.
- LOCKED, accept condition = REQ_owner & ~FULL:
  - WRITE=1, WRITEDATA=DATA_owner, ACK_owner=1, in the same cycle (combinational).
  - Counter clears.
  - If LAST_owner: next state IDLE, last_served<=owner.
- LOCKED, REQ_owner=0:
  - Counter increments.
  - When counter reaches TXARB_TIMEOUT-1 with REQ still low: next state IDLE, last_served<=owner, ERR<=1.
- LOCKED, REQ_owner=1 & FULL=1: stall. No write, no ACK, counter holds; FIFO backpressure never triggers a timeout.
- The non-owner's REQ is ignored while LOCKED; its ACK stays 0.
- o_txarb_WRITE, ACK0 and ACK1 are never high unless state is LOCKED. At most one ACK is high per cycle.
- ERR: set on timeout, cleared by i_txarb_ERRCLR. If set and clear coincide, set wins.
- o_txarb_OWNER = owner register; BUSY = (state==LOCKED).

## Timing
- Reset (i_reset=0 at a rising edge):
  - state=IDLE, owner=0, last_served=1 so requester 0 wins the first tie, counter=0, ERR=0.
  - All outputs 0, including WRITEDATA.
- Grant latency: REQ sampled high in IDLE at edge t gives BUSY=1 after t. First ACK/WRITE can occur in cycle t+1.
- Streaming: one byte per cycle while REQ_owner=1 and FULL=0.
- After a LAST accept: IDLE for one cycle, then a new grant. Minimum packet gap is 1 cycle.
- Timeout: release after exactly TXARB_TIMEOUT consecutive REQ-low cycles in LOCKED. BUSY drops on the following edge.
- Reset asserted mid-packet: the grant is dropped immediately. The requester must restart its packet.
- FULL is used combinationally, so WRITE is never asserted while FULL=1.

## Test plan
- Single packet: reset, then REQ0 with bytes 0x0A,0x0B,0xAC (LAST on 0xAC), FULL=0.
  - Required: BUSY one cycle after REQ0.
  - WRITEDATA 0x0A,0x0B,0xAC on three consecutive cycles, ACK0 on each.
  - BUSY=0 after LAST; ERR=0.
- Tie and round-robin: REQ0 and REQ1 high together, each sending 2-byte packets repeatedly.
  - Required: grant order 0,1,0,1.
  - No interleaving of bytes inside a packet.
  - ACK1 never high while OWNER=0.
- Backpressure: FULL=1 for 5 cycles in the middle of a 3-byte packet, with TXARB_TIMEOUT=10.
  - Required: no WRITE or ACK while FULL=1.
  - Remaining bytes written in order once FULL=0; ERR stays 0.
- Timeout: owner 1 writes byte 0x55 without LAST, then drops REQ1 for 10 cycles.
  - Required: BUSY falls after the 10th idle cycle and ERR=1.
  - A pending REQ0 is then granted.
  - ERRCLR pulse returns ERR to 0.
- Reset mid-packet: assert i_reset=0 for one edge during a LOCKED stream.
  - Required: all outputs 0 on the next cycle.
  - A subsequent simultaneous request is granted to requester 0.
